lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time over a req/ack memory port with optional wait timeout.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct,
    input  logic        req_load,
    input  logic        req_store,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, DONE = 2'd2} state_t;
    state_t state_reg, state_next;

    logic [1:0]  addr_lo_reg;
    logic [2:0]  funct_reg;
    logic        load_reg;
    logic [31:0] wait_reg;
    logic        mem_req_reg, mem_we_reg;
    logic [31:0] mem_addr_reg, mem_wdata_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] resp_data_reg;
    logic        resp_err_reg;

    logic        req_legal, req_misalign, req_ok;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata_rep;
    logic        ack_take, timeout_hit;
    logic [7:0]  rd_byte [4];
    logic [15:0] rd_half [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    always_comb begin
        req_legal = 1'b0;
        if (req_load && !req_store) begin
            case (req_funct)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default: req_legal = 1'b0;
            endcase
        end else if (req_store && !req_load) begin
            case (req_funct)
                3'b000, 3'b001, 3'b010: req_legal = 1'b1;
                default: req_legal = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = (req_funct[1:0] == 2'b01 && req_addr[0]) ||
                          (req_funct[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    assign req_ok = req_legal && !req_misalign;

    // Halfword lanes follow addr[1] only, so an odd halfword address lands on its aligned lane.
    always_comb begin
        req_wstrb     = 4'b1111;
        req_wdata_rep = req_wdata;
        case (req_funct[1:0])
            2'b00: begin
                req_wstrb     = 4'b0001 << req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_wstrb     = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_wstrb     = 4'b1111;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_byte
        assign rd_byte[gi] = mem_rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
        assign rd_half[gi] = mem_rdata[16*gi +: 16];
    end

    assign sel_byte = rd_byte[addr_lo_reg];
    assign sel_half = rd_half[addr_lo_reg[1]];

    always_comb begin
        load_ext = mem_rdata;
        case (funct_reg)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'd0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'd0, sel_half};
            default: load_ext = mem_rdata;
        endcase
    end

    assign ack_take    = (state_reg == MEM) && mem_req_reg && mem_ack;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((wait_reg + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_ok ? MEM : DONE;
            end
            MEM: begin
                if (ack_take || timeout_hit) state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_lo_reg   <= 2'b00;
            funct_reg     <= 3'b000;
            load_reg      <= 1'b0;
            wait_reg      <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= 4'b0000;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_reg <= req_addr[1:0];
                        funct_reg   <= req_funct;
                        load_reg    <= req_load;
                        wait_reg    <= '0;
                        if (req_ok) begin
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= req_store;
                            mem_addr_reg  <= {req_addr[31:2], 2'b00};
                            mem_wdata_reg <= req_wdata_rep;
                            mem_wstrb_reg <= req_store ? req_wstrb : 4'b0000;
                        end else begin
                            resp_err_reg <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    // An ack in the timeout cycle takes priority, so the access still succeeds.
                    if (ack_take) begin
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_wstrb_reg <= 4'b0000;
                        resp_err_reg  <= 1'b0;
                        resp_data_reg <= load_reg ? load_ext : 32'd0;
                    end else begin
                        wait_reg <= wait_reg + 32'd1;
                        if (timeout_hit) begin
                            mem_req_reg   <= 1'b0;
                            mem_we_reg    <= 1'b0;
                            mem_wstrb_reg <= 4'b0000;
                            resp_err_reg  <= 1'b1;
                            resp_data_reg <= 32'd0;
                        end
                    end
                end
                DONE: begin
                    resp_data_reg <= 32'd0;
                    resp_err_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign resp_data = resp_data_reg;
    assign resp_err  = resp_err_reg;
endmodule
